// File: rtl/hex_display_sequencer.sv
// Shares the 8-digit seven-segment display between two 12-bit sources: round-robin grant,
// serial double-dabble BCD conversion, blanked decimal encoding and a minimum dwell per result.
module hex_display_sequencer #(
  parameter int DWELL_CYCLES = 50000000,
  parameter int DWELL_WIDTH  = 26
) (
  input  logic        clk,
  input  logic        reset,
  input  logic [11:0] src0_data,
  input  logic        src0_valid,
  input  logic [11:0] src1_data,
  input  logic        src1_valid,
  output logic        busy,
  output logic        done,
  output logic        src_sel,
  output logic [55:0] HexDisplay_output
);

  localparam int DATA_W = 12;
  localparam logic [DWELL_WIDTH-1:0] DWELL_LOAD = DWELL_WIDTH'(DWELL_CYCLES);
  localparam logic [6:0] SEG_BLANK = 7'b1111111;

  typedef enum logic [1:0] {
    S_IDLE,
    S_CONVERT,
    S_ENCODE,
    S_HOLD
  } state_t;

  function automatic logic [3:0] add3(input logic [3:0] n);
    return (n >= 4'd5) ? n + 4'd3 : n;
  endfunction

  function automatic logic [15:0] dabble_adjust(input logic [15:0] b);
    return {add3(b[15:12]), add3(b[11:8]), add3(b[7:4]), add3(b[3:0])};
  endfunction

  function automatic logic [6:0] seg7(input logic [3:0] d);
    logic [6:0] s;
    case (d)
      4'd0:    s = 7'b1000000;
      4'd1:    s = 7'b1111001;
      4'd2:    s = 7'b0100100;
      4'd3:    s = 7'b0110000;
      4'd4:    s = 7'b0011001;
      4'd5:    s = 7'b0010010;
      4'd6:    s = 7'b0000010;
      4'd7:    s = 7'b1111000;
      4'd8:    s = 7'b0000000;
      4'd9:    s = 7'b0011000;
      default: s = SEG_BLANK;
    endcase
    return s;
  endfunction

  state_t                 r_state;
  logic [DATA_W-1:0]      r_cap0;
  logic [DATA_W-1:0]      r_cap1;
  logic                   r_pend0;
  logic                   r_pend1;
  logic                   r_last;
  logic                   r_gnt;
  logic [DATA_W-1:0]      r_shift;
  logic [15:0]            r_bcd;
  logic [3:0]             r_bitcnt;
  logic [DWELL_WIDTH-1:0] r_dwell;
  logic                   r_busy;
  logic                   r_done;
  logic                   r_sel;
  logic [55:0]            r_hex;

  logic        w_req_any;
  logic        w_gnt_idx;
  logic [15:0] w_bcd_adj;
  logic        w_blank3;
  logic        w_blank2;
  logic        w_blank1;
  logic [55:0] w_seg_word;

  // With both requesters pending, the one not served last wins.
  assign w_req_any = r_pend0 | r_pend1;
  assign w_gnt_idx = (r_pend0 & r_pend1) ? ~r_last : r_pend1;
  assign w_bcd_adj = dabble_adjust(r_bcd);

  assign w_blank3 = (r_bcd[15:12] == 4'd0);
  assign w_blank2 = w_blank3 && (r_bcd[11:8] == 4'd0);
  assign w_blank1 = w_blank2 && (r_bcd[7:4] == 4'd0);

  assign w_seg_word = {
    {3{SEG_BLANK}},
    seg7({3'b000, r_gnt}),
    w_blank3 ? SEG_BLANK : seg7(r_bcd[15:12]),
    w_blank2 ? SEG_BLANK : seg7(r_bcd[11:8]),
    w_blank1 ? SEG_BLANK : seg7(r_bcd[7:4]),
    seg7(r_bcd[3:0])
  };

  always_ff @(posedge clk) begin
    if (reset) begin
      r_state  <= S_IDLE;
      r_cap0   <= '0;
      r_cap1   <= '0;
      r_pend0  <= 1'b0;
      r_pend1  <= 1'b0;
      r_last   <= 1'b1;
      r_bitcnt <= '0;
      r_dwell  <= '0;
      r_busy   <= 1'b0;
      r_done   <= 1'b0;
      r_sel    <= 1'b0;
      r_hex    <= '1;
    end else begin
      r_done <= 1'b0;
      case (r_state)
        S_IDLE: begin
          if (w_req_any) begin
            r_gnt <= w_gnt_idx;
            if (w_gnt_idx) r_pend1 <= 1'b0;
            else           r_pend0 <= 1'b0;
            r_shift  <= w_gnt_idx ? r_cap1 : r_cap0;
            r_bcd    <= '0;
            r_bitcnt <= 4'd12;
            r_busy   <= 1'b1;
            r_state  <= S_CONVERT;
          end
        end
        S_CONVERT: begin
          {r_bcd, r_shift} <= {w_bcd_adj[14:0], r_shift, 1'b0};
          r_bitcnt         <= r_bitcnt - 4'd1;
          if (r_bitcnt == 4'd1) r_state <= S_ENCODE;
        end
        S_ENCODE: begin
          r_hex   <= w_seg_word;
          r_sel   <= r_gnt;
          r_last  <= r_gnt;
          r_done  <= 1'b1;
          r_dwell <= DWELL_LOAD;
          if (DWELL_CYCLES == 0) begin
            r_busy  <= 1'b0;
            r_state <= S_IDLE;
          end else begin
            r_state <= S_HOLD;
          end
        end
        S_HOLD: begin
          if (r_dwell == '0) begin
            r_busy  <= 1'b0;
            r_state <= S_IDLE;
          end else begin
            r_dwell <= r_dwell - DWELL_WIDTH'(1);
          end
        end
        default: r_state <= S_IDLE;
      endcase
      // Captures follow the grant so a strobe on the grant edge re-arms the request.
      if (src0_valid) begin
        r_cap0  <= src0_data;
        r_pend0 <= 1'b1;
      end
      if (src1_valid) begin
        r_cap1  <= src1_data;
        r_pend1 <= 1'b1;
      end
    end
  end

  assign busy              = r_busy;
  assign done              = r_done;
  assign src_sel           = r_sel;
  assign HexDisplay_output = r_hex;

endmodule

// File: tb/tb_hex_display_sequencer.sv
// Bench for hex_display_sequencer: directed scenarios plus random strobes, each cycle
// compared against a transaction-level model built from decimal arithmetic.
module tb_hex_display_sequencer;

  localparam int DW    = 20;
  localparam int M_END = (DW == 0) ? 13 : 14 + DW;

  localparam logic [6:0] G0 = 7'b1000000, G1 = 7'b1111001, G2 = 7'b0100100,
                         G3 = 7'b0110000, G4 = 7'b0011001, G5 = 7'b0010010,
                         G6 = 7'b0000010, G7 = 7'b1111000, G9 = 7'b0011000,
                         BL = 7'b1111111;
  localparam logic [20:0] ONES21 = 21'h1FFFFF;

  logic        clk = 1'b0;
  logic        reset = 1'b1;
  logic [11:0] src0_data = '0;
  logic        src0_valid = 1'b0;
  logic [11:0] src1_data = '0;
  logic        src1_valid = 1'b0;
  logic        busy;
  logic        done;
  logic        src_sel;
  logic [55:0] HexDisplay_output;

  always #5 clk = ~clk;

  hex_display_sequencer #(.DWELL_CYCLES(DW), .DWELL_WIDTH(8)) dut (
    .clk               (clk),
    .reset             (reset),
    .src0_data         (src0_data),
    .src0_valid        (src0_valid),
    .src1_data         (src1_data),
    .src1_valid        (src1_valid),
    .busy              (busy),
    .done              (done),
    .src_sel           (src_sel),
    .HexDisplay_output (HexDisplay_output)
  );

  int checks = 0;
  int errors = 0;

  function automatic logic [6:0] glyph(input int d);
    case (d)
      0: return 7'b1000000;
      1: return 7'b1111001;
      2: return 7'b0100100;
      3: return 7'b0110000;
      4: return 7'b0011001;
      5: return 7'b0010010;
      6: return 7'b0000010;
      7: return 7'b1111000;
      8: return 7'b0000000;
      9: return 7'b0011000;
      default: return 7'b1111111;
    endcase
  endfunction

  function automatic logic [55:0] word(input int v, input int s);
    logic [6:0] h3, h2, h1;
    h3 = (v < 1000) ? BL : glyph(v / 1000);
    h2 = (v < 100)  ? BL : glyph((v / 100) % 10);
    h1 = (v < 10)   ? BL : glyph((v / 10) % 10);
    return {ONES21, glyph(s), h3, h2, h1, glyph(v % 10)};
  endfunction

  // Transaction model: a served request lasts M_END edges after its grant, result at edge 13.
  logic [1:0]  m_pend = '0;
  int          m_cap0 = 0, m_cap1 = 0, m_last = 1, m_g = 0, m_val = 0, m_age = 0;
  bit          m_serving = 0;
  logic [55:0] m_out = '1;
  logic        m_sel = 0, m_done = 0, m_busy = 0;

  always @(posedge clk) begin
    if (reset) begin
      m_pend = '0; m_cap0 = 0; m_cap1 = 0; m_last = 1; m_serving = 0; m_age = 0;
      m_out = '1; m_sel = 0; m_done = 0; m_busy = 0;
    end else begin
      m_done = 0;
      if (m_serving) begin
        m_age++;
        if (m_age == 13) begin
          m_out = word(m_val, m_g); m_sel = (m_g == 1); m_last = m_g; m_done = 1;
        end
        if (m_age == M_END) begin
          m_serving = 0; m_busy = 0;
        end
      end else if (m_pend != 2'b00) begin
        m_g = (m_pend == 2'b11) ? 1 - m_last : (m_pend[1] ? 1 : 0);
        m_val = (m_g == 1) ? m_cap1 : m_cap0;
        m_pend[m_g] = 1'b0;
        m_serving = 1; m_age = 0; m_busy = 1;
      end
      if (src0_valid) begin m_cap0 = src0_data; m_pend[0] = 1'b1; end
      if (src1_valid) begin m_cap1 = src1_data; m_pend[1] = 1'b1; end
    end
  end

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  // One clock: compare all outputs with the model after the edge, then drop strobes.
  task automatic tick();
    @(posedge clk);
    @(negedge clk);
    chk("hex", HexDisplay_output, m_out);
    chk("busy", busy, m_busy);
    chk("done", done, m_done);
    chk("src_sel", src_sel, m_sel);
    src0_valid = 1'b0;
    src1_valid = 1'b0;
  endtask

  task automatic strobe(input bit v0, input int d0, input bit v1, input int d1);
    src0_valid = v0; src0_data = 12'(d0);
    src1_valid = v1; src1_data = 12'(d1);
  endtask

  task automatic wait_done(input string tag);
    int n = 0;
    while (done !== 1'b1 && n < 200) begin tick(); n++; end
    chk({tag, "_done_seen"}, done, 1'b1);
  endtask

  task automatic wait_idle(input string tag);
    int n = 0;
    while (busy !== 1'b0 && n < 200) begin tick(); n++; end
    chk({tag, "_idle_seen"}, busy, 1'b0);
  endtask

  initial begin
    int n;
    bit seen;

    // Reset for three cycles; a strobe during reset must be ignored.
    @(negedge clk);
    reset = 1'b1;
    for (int i = 0; i < 3; i++) begin strobe(1, 123, 1, 456); tick(); end
    reset = 1'b0;
    for (int i = 0; i < 6; i++) tick();
    chk("rst_hex", HexDisplay_output, {56{1'b1}});
    chk("rst_busy", busy, 1'b0);
    chk("rst_done", done, 1'b0);
    chk("rst_sel", src_sel, 1'b0);

    // src0 = 0: result exactly 14 edges after the strobe edge.
    strobe(1, 0, 0, 0);
    tick();
    for (int i = 0; i < 13; i++) tick();
    chk("v0_pre_hex", HexDisplay_output, {56{1'b1}});
    tick();
    chk("v0_hex", HexDisplay_output, {ONES21, G0, ONES21, G0});
    chk("v0_done", done, 1'b1);
    tick();
    chk("v0_done_once", done, 1'b0);
    wait_idle("v0");

    // src1 = 4095.
    strobe(0, 0, 1, 4095);
    tick();
    wait_done("v4095");
    chk("v4095_hex", HexDisplay_output, {ONES21, G1, G4, G0, G9, G5});
    chk("v4095_sel", src_sel, 1'b1);
    wait_idle("v4095");

    // Simultaneous strobes: src0 first, src1 exactly 35 cycles later.
    strobe(1, 1234, 1, 56);
    tick();
    wait_done("both_a");
    chk("both_a_hex", HexDisplay_output, {ONES21, G0, G1, G2, G3, G4});
    n = 0;
    tick(); n++;
    while (done !== 1'b1 && n < 100) begin tick(); n++; end
    chk("both_gap", n, 35);
    chk("both_b_hex", HexDisplay_output, {ONES21, G1, BL, BL, G5, G6});
    chk("both_b_sel", src_sel, 1'b1);
    wait_idle("both");

    // Latest-wins: 10, then 20 during CONVERT, 30 during HOLD -> 10 then 30.
    strobe(1, 10, 0, 0);
    tick();
    tick(); tick(); tick();
    strobe(1, 20, 0, 0);
    tick();
    wait_done("lw10");
    chk("lw10_hex", HexDisplay_output, {ONES21, G0, BL, BL, G1, G0});
    tick(); tick(); tick();
    strobe(1, 30, 0, 0);
    tick();
    wait_done("lw30");
    chk("lw30_hex", HexDisplay_output, {ONES21, G0, BL, BL, G3, G0});
    wait_idle("lw");

    // Show "7", then reset on the 6th CONVERT cycle of the next request.
    strobe(1, 7, 0, 0);
    tick();
    wait_done("r7");
    chk("r7_hex", HexDisplay_output, {ONES21, G0, BL, BL, BL, G7});
    wait_idle("r7");
    strobe(1, 999, 0, 0);
    tick();
    tick();
    for (int i = 0; i < 5; i++) tick();
    reset = 1'b1;
    tick();
    reset = 1'b0;
    chk("rmid_hex", HexDisplay_output, {56{1'b1}});
    chk("rmid_busy", busy, 1'b0);
    seen = 0;
    for (int i = 0; i < 40; i++) begin tick(); if (done === 1'b1) seen = 1; end
    chk("rmid_no_done", seen, 1'b0);
    chk("rmid_hex_after", HexDisplay_output, {56{1'b1}});

    // Random strobes with occasional resets.
    for (int i = 0; i < 3000; i++) begin
      strobe(($urandom_range(0, 24) == 0), $urandom_range(0, 4095),
             ($urandom_range(0, 24) == 0), $urandom_range(0, 4095));
      reset = ($urandom_range(0, 599) == 0);
      tick();
    end
    reset = 1'b0;
    tick();

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
